// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: front-end controller for a shared 16-bit ADD/SUB ALU.
// Runs ADD/SUB in one ALU pass; unsigned MUL and DIV are 16-step loops built on ADD/SUB.
module alu_op_sequencer #(
    parameter int          DATA_W    = 16,
    parameter logic [15:0] DIV0_QUOT = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [DATA_W-1:0] rsp_ext,
    output logic [3:0]        rsp_flags,
    output logic              rsp_err,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic              alu_c,
    input  logic              alu_o
);
    typedef enum logic [2:0] {IDLE, EXEC, MUL, DIV, DONE} state_t;
    state_t            r_state, w_next;
    logic [DATA_W-1:0] r_a, r_b, r_hi, r_lo;
    logic [2:0]        r_op;
    logic [4:0]        r_cnt;
    logic              w_accept, w_ok, w_last;
    logic [DATA_W:0]   w_sum;
    logic [2*DATA_W:0] w_shift;
    assign w_accept  = req_valid & req_ready;
    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == DONE);
    assign w_last    = (r_cnt == 5'd16);
    // MUL: r_hi/r_lo hold the partial product; DIV: r_hi is the remainder, r_lo the quotient
    assign w_sum   = r_lo[0] ? {alu_c, alu_out} : {1'b0, r_hi};
    assign w_shift = {w_sum, r_lo} >> 1;
    assign w_ok    = r_hi[DATA_W-1] | ~alu_c;
    always_comb begin
        w_next     = r_state;
        alu_a      = '0;
        alu_b      = '0;
        alu_opcode = 3'b000;
        case (r_state)
            IDLE: if (w_accept) begin
                case (req_op)
                    3'b000, 3'b001: w_next = EXEC;
                    3'b010:         w_next = MUL;
                    3'b011:         w_next = (req_b == '0) ? DONE : DIV;
                    default:        w_next = DONE;
                endcase
            end
            EXEC: begin
                alu_a      = r_a;
                alu_b      = r_b;
                alu_opcode = r_op;
                w_next     = DONE;
            end
            MUL: begin
                alu_a  = r_hi;
                alu_b  = r_b;
                w_next = w_last ? DONE : MUL;
            end
            DIV: begin
                alu_a      = {r_hi[DATA_W-2:0], r_lo[DATA_W-1]};
                alu_b      = r_b;
                alu_opcode = 3'b001;
                w_next     = w_last ? DONE : DIV;
            end
            DONE: w_next = rsp_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_cnt      <= '0;
            rsp_result <= '0;
            rsp_ext    <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_a   <= req_a;
                    r_b   <= req_b;
                    r_op  <= req_op;
                    r_hi  <= '0;
                    r_lo  <= req_a;
                    r_cnt <= '0;
                    if (req_op == 3'b011 && req_b == '0) begin
                        rsp_result <= DIV0_QUOT;
                        rsp_ext    <= req_a;
                        rsp_flags  <= 4'b0110;
                        rsp_err    <= 1'b1;
                    end else if (req_op[2]) begin
                        rsp_result <= '0;
                        rsp_ext    <= '0;
                        rsp_flags  <= '0;
                        rsp_err    <= 1'b1;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_out;
                    rsp_ext    <= '0;
                    rsp_flags  <= {alu_z, alu_n, alu_c, alu_o};
                    rsp_err    <= 1'b0;
                end
                MUL: if (w_last) begin
                    rsp_result <= r_lo;
                    rsp_ext    <= r_hi;
                    rsp_flags  <= {({r_hi, r_lo} == '0), r_lo[DATA_W-1], {2{r_hi != '0}}};
                    rsp_err    <= 1'b0;
                end else begin
                    {r_hi, r_lo} <= w_shift[2*DATA_W-1:0];
                    r_cnt        <= r_cnt + 5'd1;
                end
                DIV: if (w_last) begin
                    rsp_result <= r_lo;
                    rsp_ext    <= r_hi;
                    rsp_flags  <= {(r_lo == '0), 3'b000};
                    rsp_err    <= 1'b0;
                end else begin
                    r_hi  <= w_ok ? alu_out : alu_a;
                    r_lo  <= {r_lo[DATA_W-2:0], w_ok};
                    r_cnt <= r_cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed table, random ops against an arithmetic reference model,
// and hand sequences for hold, busy-ignore and mid-operation reset.
module tb_alu_op_sequencer;
    logic        clk = 0, rst_n = 0;
    logic        req_valid = 0, req_ready, rsp_valid, rsp_ready = 0, rsp_err;
    logic [2:0]  req_op = 0, alu_opcode;
    logic [15:0] req_a = 0, req_b = 0, rsp_result, rsp_ext, alu_a, alu_b, alu_out;
    logic [3:0]  rsp_flags;
    logic        alu_z, alu_n, alu_c, alu_o;
    int          n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_ext(rsp_ext),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err), .alu_a(alu_a), .alu_b(alu_b),
        .alu_opcode(alu_opcode), .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n),
        .alu_c(alu_c), .alu_o(alu_o)
    );

    // Shared ALU: C is carry-out for ADD and borrow (a<b) for SUB
    logic [16:0] alu_wide;
    always_comb begin
        alu_wide = (alu_opcode == 3'b001) ? ({1'b0, alu_a} - {1'b0, alu_b}) : ({1'b0, alu_a} + {1'b0, alu_b});
        alu_out  = alu_wide[15:0];
        alu_c    = alu_wide[16];
        alu_z    = (alu_out == 16'h0);
        alu_n    = alu_out[15];
        alu_o    = (alu_opcode == 3'b001) ? ((alu_a[15] != alu_b[15]) && (alu_out[15] != alu_a[15]))
                                          : ((alu_a[15] == alu_b[15]) && (alu_out[15] != alu_a[15]));
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: what the response should be, from plain unsigned arithmetic
    task automatic model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic [15:0] e, output logic [3:0] f,
                         output logic err, output int lat);
        logic [31:0] p;
        int s;
        err = 0; e = 0; lat = 2;
        if (op == 3'd0 || op == 3'd1) begin
            s = (op == 3'd0) ? int'(a) + int'(b) : int'(a) - int'(b);
            r = s[15:0];
            f = {r == 16'h0, r[15], (op == 3'd0) ? (s > 65535) : (a < b),
                 (op == 3'd0) ? (a[15] == b[15] && r[15] != a[15]) : (a[15] != b[15] && r[15] != a[15])};
        end else if (op == 3'd2) begin
            p = 32'(a) * 32'(b);
            r = p[15:0]; e = p[31:16]; lat = 18;
            f = {p == 0, p[15], p[31:16] != 0, p[31:16] != 0};
        end else if (op == 3'd3 && b != 0) begin
            r = a / b; e = a % b; lat = 18;
            f = {r == 0, 3'b000};
        end else if (op == 3'd3) begin
            r = 16'hFFFF; e = a; f = 4'b0110; err = 1; lat = 1;
        end else begin
            r = 0; f = 0; err = 1; lat = 1;
        end
    endtask

    task automatic run(input string nm, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input int hold, input logic [15:0] er, input logic [15:0] ee,
                       input logic [3:0] ef, input logic eerr, input int elat);
        int lat;
        logic [38:0] snap;
        @(negedge clk);
        chk({nm, "_req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1; req_op = op; req_a = a; req_b = b; rsp_ready = 0;
        @(negedge clk);
        req_valid = 0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'(elat));
        chk({nm, "_result"}, 64'(rsp_result), 64'(er));
        chk({nm, "_ext"}, 64'(rsp_ext), 64'(ee));
        chk({nm, "_flags_err"}, 64'({rsp_flags, rsp_err}), 64'({ef, eerr}));
        snap = {1'b1, 1'b0, er, ee, ef, eerr};
        repeat (hold) begin
            @(negedge clk);
            chk({nm, "_hold"}, 64'({rsp_valid, req_ready, rsp_result, rsp_ext, rsp_flags, rsp_err}), 64'(snap));
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk({nm, "_handshake"}, 64'({rsp_valid, req_ready}), 64'(2'b01));
    endtask

    task automatic run_model(input string nm, input logic [2:0] op, input logic [15:0] a,
                             input logic [15:0] b, input int hold);
        logic [15:0] r, e;
        logic [3:0] f;
        logic err;
        int lat;
        model(op, a, b, r, e, f, err, lat);
        run(nm, op, a, b, hold, r, e, f, err, lat);
    endtask

    typedef struct {
        string       nm;
        logic [2:0]  op;
        logic [15:0] a, b;
        int          hold;
        logic [15:0] r, e;
        logic [3:0]  f;
        logic        err;
        int          lat;
    } vec_t;
    vec_t vecs[12];

    initial begin
        vecs[0]  = '{"add_wrap",  3'd0, 16'hFFFF, 16'h0001, 0, 16'h0000, 16'h0000, 4'b1010, 1'b0, 2};
        vecs[1]  = '{"sub_ovf",   3'd1, 16'h8000, 16'h0001, 5, 16'h7FFF, 16'h0000, 4'b0001, 1'b0, 2};
        vecs[2]  = '{"mul_1234",  3'd2, 16'h1234, 16'h5678, 0, 16'h0060, 16'h0626, 4'b0011, 1'b0, 18};
        vecs[3]  = '{"div_1000",  3'd3, 16'd1000, 16'd7,    0, 16'h008E, 16'h0006, 4'b0000, 1'b0, 18};
        vecs[4]  = '{"div_ffff",  3'd3, 16'hFFFF, 16'hFFFF, 0, 16'h0001, 16'h0000, 4'b0000, 1'b0, 18};
        vecs[5]  = '{"div_zero",  3'd3, 16'h1234, 16'h0000, 2, 16'hFFFF, 16'h1234, 4'b0110, 1'b1, 1};
        vecs[6]  = '{"illegal",   3'd5, 16'h0005, 16'h0006, 0, 16'h0000, 16'h0000, 4'b0000, 1'b1, 1};
        vecs[7]  = '{"mul_max",   3'd2, 16'hFFFF, 16'hFFFF, 0, 16'h0001, 16'hFFFE, 4'b0011, 1'b0, 18};
        vecs[8]  = '{"mul_zero",  3'd2, 16'h0000, 16'h1234, 0, 16'h0000, 16'h0000, 4'b1000, 1'b0, 18};
        vecs[9]  = '{"sub_borrow",3'd1, 16'h0000, 16'h0001, 0, 16'hFFFF, 16'h0000, 4'b0110, 1'b0, 2};
        vecs[10] = '{"div_small", 3'd3, 16'd5,    16'd9,    0, 16'h0000, 16'h0005, 4'b1000, 1'b0, 18};
        vecs[11] = '{"add_ovf",   3'd0, 16'h7FFF, 16'h0001, 1, 16'h8000, 16'h0000, 4'b0101, 1'b0, 2};

        repeat (3) @(negedge clk);
        chk("reset_state", 64'({req_ready, rsp_valid, rsp_result, rsp_ext, rsp_flags, rsp_err}),
            64'({1'b1, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0}));
        chk("reset_alu", 64'({alu_a, alu_b, alu_opcode}), 64'd0);
        rst_n = 1;

        foreach (vecs[i])
            run(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold,
                vecs[i].r, vecs[i].e, vecs[i].f, vecs[i].err, vecs[i].lat);

        // A request held during MUL must wait until the MUL response has been taken
        @(negedge clk);
        req_valid = 1; req_op = 3'd2; req_a = 16'd300; req_b = 16'd500;
        @(negedge clk);
        req_op = 3'd0; req_a = 16'd5; req_b = 16'd6;
        for (int k = 0; k < 40 && !rsp_valid; k++) @(negedge clk);
        chk("busy_mul_result", 64'({rsp_ext, rsp_result}), 64'(32'd150000));
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("busy_no_b2b", 64'({rsp_valid, req_ready}), 64'(2'b01));
        @(negedge clk);
        req_valid = 0;
        chk("busy_accepted", 64'(req_ready), 64'd0);
        for (int k = 0; k < 40 && !rsp_valid; k++) @(negedge clk);
        chk("busy_add_result", 64'({rsp_valid, rsp_result, rsp_err}), 64'({1'b1, 16'd11, 1'b0}));
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;

        // Reset in the middle of a MUL aborts it with no response
        @(negedge clk);
        req_valid = 1; req_op = 3'd2; req_a = 16'd3; req_b = 16'd5;
        @(negedge clk);
        req_valid = 0;
        repeat (7) @(negedge clk);
        chk("mid_mul_busy", 64'(req_ready), 64'd0);
        rst_n = 0;
        #1;
        chk("abort_state", 64'({req_ready, rsp_valid}), 64'(2'b10));
        chk("abort_alu", 64'({alu_a, alu_b, alu_opcode}), 64'd0);
        @(negedge clk);
        rst_n = 1;
        run_model("after_reset", 3'd2, 16'd3, 16'd5, 0);

        for (int i = 0; i < 60; i++) begin
            logic [2:0] op;
            logic [15:0] a, b;
            op = 3'($urandom_range(0, 4));
            if (op == 3'd4) op = 3'($urandom_range(4, 7));
            a = 16'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(1, 20));
            run_model("random", op, a, b, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
